// File: rtl/mmio_chan_map_pkg.sv
// Shared register map, status bit layout and widths for the MMIO channel map.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mmio_chan_map_pkg;

  localparam int MMIO_AW      = 16;
  localparam int MMIO_DW      = 64;
  localparam int REJECT_CNT_W = 16;
  localparam int CYCLE_CNT_W  = 32;

  // Per-channel word offsets from the channel base address.
  localparam logic [MMIO_AW-1:0] OFF_CTRL           = 16'h0;
  localparam logic [MMIO_AW-1:0] OFF_RD_ADDR        = 16'h2;
  localparam logic [MMIO_AW-1:0] OFF_WR_ADDR        = 16'h4;
  localparam logic [MMIO_AW-1:0] OFF_NUM_SAMPLES    = 16'h6;
  localparam logic [MMIO_AW-1:0] OFF_COLLECT_CYCLES = 16'h8;
  localparam logic [MMIO_AW-1:0] OFF_STATUS         = 16'hA;
  localparam logic [MMIO_AW-1:0] OFF_CYCLE_CNT      = 16'hC;

  // Global word offsets from the end of the channel block.
  localparam logic [MMIO_AW-1:0] OFF_DONE_MASK      = 16'h0;
  localparam logic [MMIO_AW-1:0] OFF_REJECT_CNT     = 16'h2;

  // STATUS register bit positions.
  localparam int ST_BUSY = 0;
  localparam int ST_DONE = 1;
  localparam int ST_ERR  = 2;

  // Config register select driven from the top-level decode.
  typedef enum logic [1:0] {
    CFG_RD_ADDR        = 2'd0,
    CFG_WR_ADDR        = 2'd1,
    CFG_NUM_SAMPLES    = 2'd2,
    CFG_COLLECT_CYCLES = 2'd3
  } cfg_sel_t;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_BUSY = 1'b1
  } ch_state_t;

  // Word address of channel c's register block.
  function automatic logic [MMIO_AW-1:0] ch_base(input logic [MMIO_AW-1:0] base,
                                                  input logic [MMIO_AW-1:0] stride,
                                                  input int c);
    return MMIO_AW'(base + c * stride);
  endfunction

endpackage

// File: rtl/mmio_if.sv
// Host MMIO bundle: single-cycle write strobe, read request with registered data.
// Latency: rd_data one cycle after rd_en.
// Backpressure: none; every request is accepted.
interface mmio_if;
  logic                                   wr_en;
  logic [mmio_chan_map_pkg::MMIO_AW-1:0]  wr_addr;
  logic [mmio_chan_map_pkg::MMIO_DW-1:0]  wr_data;
  logic                                   rd_en;
  logic [mmio_chan_map_pkg::MMIO_AW-1:0]  rd_addr;
  logic [mmio_chan_map_pkg::MMIO_DW-1:0]  rd_data;

  modport user (input wr_en, wr_addr, wr_data, rd_en, rd_addr, output rd_data);
  modport host (output wr_en, wr_addr, wr_data, rd_en, rd_addr, input rd_data);
endinterface

// File: rtl/mmio_chan_ctrl.sv
// One DMA channel: IDLE/BUSY FSM, config registers, sticky status, optional busy-cycle counter.
// Latency: go/abort pulse the cycle after the accepted CTRL write; state updates in one cycle.
// Backpressure: none; writes while BUSY are dropped and flagged via reject. Counter: MMIO_CHAN_MAP_CYCLE_CNT_EN.
module mmio_chan_ctrl
  import mmio_chan_map_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int SIZE_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ctrl_wr,
  input  logic                   cfg_wr,
  input  cfg_sel_t               cfg_sel,
  input  logic [MMIO_DW-1:0]     wr_data,
  input  logic                   status_rd,
  input  logic                   done,
  output logic [ADDR_WIDTH-1:0]  cfg_rd_addr,
  output logic [ADDR_WIDTH-1:0]  cfg_wr_addr,
  output logic [SIZE_WIDTH-1:0]  cfg_num_samples,
  output logic [SIZE_WIDTH-1:0]  cfg_collect_cycles,
  output logic                   go,
  output logic                   abort,
  output logic [2:0]             status,
  output logic [CYCLE_CNT_W-1:0] cycle_cnt,
  output logic                   reject
);

  ch_state_t state, state_nxt;
  logic      accept_go, accept_abort, done_set;
  logic      done_sticky, err;

  // State register; reset drops BUSY silently, no abort pulse.
  always_ff @(posedge clk) begin
    if (rst) state <= CH_IDLE;
    else     state <= state_nxt;
  end

  // Next state and accept/reject decisions, all based on the registered state.
  always_comb begin
    state_nxt    = state;
    accept_go    = 1'b0;
    accept_abort = 1'b0;
    reject       = 1'b0;
    done_set     = 1'b0;
    case (state)
      CH_IDLE: begin
        if (ctrl_wr && wr_data[0]) begin
          accept_go = 1'b1;
          state_nxt = CH_BUSY;
        end
      end
      CH_BUSY: begin
        reject = (ctrl_wr && wr_data[0]) || cfg_wr;
        // An abort in the same cycle as done wins: the job is reported as aborted.
        if (ctrl_wr && wr_data[1]) begin
          accept_abort = 1'b1;
          state_nxt    = CH_IDLE;
        end else if (done) begin
          done_set  = 1'b1;
          state_nxt = CH_IDLE;
        end
      end
      default: state_nxt = CH_IDLE;
    endcase
  end

  // Config registers only take writes while IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_rd_addr        <= '0;
      cfg_wr_addr        <= '0;
      cfg_num_samples    <= '0;
      cfg_collect_cycles <= '0;
    end else if (cfg_wr && state == CH_IDLE) begin
      case (cfg_sel)
        CFG_RD_ADDR:        cfg_rd_addr        <= wr_data[ADDR_WIDTH-1:0];
        CFG_WR_ADDR:        cfg_wr_addr        <= wr_data[ADDR_WIDTH-1:0];
        CFG_NUM_SAMPLES:    cfg_num_samples    <= wr_data[SIZE_WIDTH-1:0];
        CFG_COLLECT_CYCLES: cfg_collect_cycles <= wr_data[SIZE_WIDTH-1:0];
      endcase
    end
  end

  // Sticky bits and one-cycle pulses; a set in the same cycle beats the read-clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_sticky <= 1'b0;
      err         <= 1'b0;
      go          <= 1'b0;
      abort       <= 1'b0;
    end else begin
      go    <= accept_go;
      abort <= accept_abort;
      if (done_set)                    done_sticky <= 1'b1;
      else if (accept_go || status_rd) done_sticky <= 1'b0;
      if (reject)                      err <= 1'b1;
      else if (accept_go || status_rd) err <= 1'b0;
    end
  end

  // Assemble STATUS from the registered state and sticky bits.
  always_comb begin
    status          = '0;
    status[ST_BUSY] = (state == CH_BUSY);
    status[ST_DONE] = done_sticky;
    status[ST_ERR]  = err;
  end

`ifdef MMIO_CHAN_MAP_CYCLE_CNT_EN
  // Busy-cycle counter: cleared by an accepted go, saturates, holds once idle.
  always_ff @(posedge clk) begin
    if (rst)                                      cycle_cnt <= '0;
    else if (accept_go)                           cycle_cnt <= '0;
    else if (state == CH_BUSY && cycle_cnt != '1) cycle_cnt <= cycle_cnt + 1'b1;
  end
`else
  assign cycle_cnt = '0;
`endif

endmodule

// File: rtl/mmio_chan_map.sv
// MMIO register map for NUM_CH DMA channels: address decode, read mux, global REJECT_CNT.
// Latency: rd_data registered one cycle after rd_en; writes take effect on the next edge.
// Backpressure: none; writes to busy channels are dropped and counted. Option: MMIO_CHAN_MAP_CYCLE_CNT_EN.
module mmio_chan_map
  import mmio_chan_map_pkg::*;
#(
  parameter int                 ADDR_WIDTH = 64,
  parameter int                 SIZE_WIDTH = 32,
  parameter int                 NUM_CH     = 4,
  parameter logic [MMIO_AW-1:0] BASE_ADDR  = 16'h0050,
  parameter logic [MMIO_AW-1:0] CH_STRIDE  = 16'h0010
) (
  input  logic                                 clk,
  input  logic                                 rst,
  mmio_if.user                                 mmio,
  output logic [NUM_CH-1:0][ADDR_WIDTH-1:0]    rd_addr,
  output logic [NUM_CH-1:0][ADDR_WIDTH-1:0]    wr_addr,
  output logic [NUM_CH-1:0][SIZE_WIDTH-1:0]    num_samples,
  output logic [NUM_CH-1:0][SIZE_WIDTH-1:0]    collect_cycles,
  output logic [NUM_CH-1:0]                    go,
  output logic [NUM_CH-1:0]                    abort,
  input  logic [NUM_CH-1:0]                    done
);

  localparam logic [MMIO_AW-1:0] G_ADDR = ch_base(BASE_ADDR, CH_STRIDE, NUM_CH);

  logic [NUM_CH-1:0][2:0]             status;
  logic [NUM_CH-1:0][CYCLE_CNT_W-1:0] cycle_cnt;
  logic [NUM_CH-1:0]                  reject;
  logic [REJECT_CNT_W-1:0]            reject_cnt;
  logic [MMIO_DW-1:0]                 rd_mux;
  logic [NUM_CH-1:0]                  done_mask;
  logic [MMIO_AW-1:0]                 rd_base;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    localparam logic [MMIO_AW-1:0] A = ch_base(BASE_ADDR, CH_STRIDE, c);

    logic     ctrl_wr, cfg_wr, status_rd;
    cfg_sel_t cfg_sel;

    // Write/read strobe decode for this channel's register block.
    always_comb begin
      ctrl_wr   = mmio.wr_en && (mmio.wr_addr == A + OFF_CTRL);
      status_rd = mmio.rd_en && (mmio.rd_addr == A + OFF_STATUS);
      cfg_wr    = 1'b0;
      cfg_sel   = CFG_RD_ADDR;
      if (mmio.wr_en) begin
        if (mmio.wr_addr == A + OFF_RD_ADDR) begin
          cfg_wr = 1'b1; cfg_sel = CFG_RD_ADDR;
        end else if (mmio.wr_addr == A + OFF_WR_ADDR) begin
          cfg_wr = 1'b1; cfg_sel = CFG_WR_ADDR;
        end else if (mmio.wr_addr == A + OFF_NUM_SAMPLES) begin
          cfg_wr = 1'b1; cfg_sel = CFG_NUM_SAMPLES;
        end else if (mmio.wr_addr == A + OFF_COLLECT_CYCLES) begin
          cfg_wr = 1'b1; cfg_sel = CFG_COLLECT_CYCLES;
        end
      end
    end

    mmio_chan_ctrl #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .SIZE_WIDTH (SIZE_WIDTH)
    ) u_ctrl (
      .clk                (clk),
      .rst                (rst),
      .ctrl_wr            (ctrl_wr),
      .cfg_wr             (cfg_wr),
      .cfg_sel            (cfg_sel),
      .wr_data            (mmio.wr_data),
      .status_rd          (status_rd),
      .done               (done[c]),
      .cfg_rd_addr        (rd_addr[c]),
      .cfg_wr_addr        (wr_addr[c]),
      .cfg_num_samples    (num_samples[c]),
      .cfg_collect_cycles (collect_cycles[c]),
      .go                 (go[c]),
      .abort              (abort[c]),
      .status             (status[c]),
      .cycle_cnt          (cycle_cnt[c]),
      .reject             (reject[c])
    );
  end

  // Read mux; anything not matched (including CTRL) reads zero.
  always_comb begin
    rd_mux    = '0;
    rd_base   = '0;
    done_mask = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      done_mask[c] = status[c][ST_DONE];
      rd_base      = ch_base(BASE_ADDR, CH_STRIDE, c);
      if (mmio.rd_addr == rd_base + OFF_RD_ADDR)        rd_mux = 64'(rd_addr[c]);
      if (mmio.rd_addr == rd_base + OFF_WR_ADDR)        rd_mux = 64'(wr_addr[c]);
      if (mmio.rd_addr == rd_base + OFF_NUM_SAMPLES)    rd_mux = 64'(num_samples[c]);
      if (mmio.rd_addr == rd_base + OFF_COLLECT_CYCLES) rd_mux = 64'(collect_cycles[c]);
      if (mmio.rd_addr == rd_base + OFF_STATUS)         rd_mux = 64'(status[c]);
      if (mmio.rd_addr == rd_base + OFF_CYCLE_CNT)      rd_mux = 64'(cycle_cnt[c]);
    end
    if (mmio.rd_addr == G_ADDR + OFF_DONE_MASK)  rd_mux = 64'(done_mask);
    if (mmio.rd_addr == G_ADDR + OFF_REJECT_CNT) rd_mux = 64'(reject_cnt);
  end

  // Registered read data; samples pre-write register values on a same-cycle write.
  always_ff @(posedge clk) begin
    if (rst)             mmio.rd_data <= '0;
    else if (mmio.rd_en) mmio.rd_data <= rd_mux;
  end

  // Saturating reject counter; any host write to it clears it.
  always_ff @(posedge clk) begin
    if (rst)
      reject_cnt <= '0;
    else if (mmio.wr_en && mmio.wr_addr == G_ADDR + OFF_REJECT_CNT)
      reject_cnt <= '0;
    else if (|reject && reject_cnt != '1)
      reject_cnt <= reject_cnt + 1'b1;
  end

endmodule
